// File: rtl/display_scan.sv
// display_scan: four-digit common-anode scanner with per-digit dead time and per-frame input snapshot.
module display_scan #(
   parameter int DWELL = 1000,
   parameter int BLANK = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [27:0] seg_in,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_start
);
   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
   localparam logic [15:0] BL = 16'(BLANK - 1);
   localparam logic [15:0] DW = 16'(DWELL - 1);
   state_t      state, state_n;
   logic [1:0]  d, d_n;
   logic [15:0] cnt, cnt_n;
   logic [31:0] snap, snap_n;
   logic        fs_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   always_comb begin
      state_n = state;
      d_n     = d;
      cnt_n   = cnt + 16'd1;
      snap_n  = snap;
      fs_n    = 1'b0;
      if (!enable) begin
         state_n = S_IDLE;
         d_n     = 2'd0;
         cnt_n   = 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               state_n = S_BLANK;
               d_n     = 2'd0;
               cnt_n   = 16'd0;
               snap_n  = {seg_in, dp_in};
               fs_n    = 1'b1;
            end
            S_BLANK: if (cnt == BL) begin
               state_n = S_SHOW;
               cnt_n   = 16'd0;
            end
            S_SHOW: if (cnt == DW) begin
               state_n = S_BLANK;
               d_n     = d + 2'd1;
               cnt_n   = 16'd0;
               snap_n  = (d == 2'd3) ? {seg_in, dp_in} : snap;
               fs_n    = (d == 2'd3);
            end
            default: begin
               state_n = S_IDLE;
               d_n     = 2'd0;
               cnt_n   = 16'd0;
            end
         endcase
      end
   end
   // outputs are derived from the next state so they land on the same edge as the transition
   always_comb begin
      seg_n = (state_n == S_IDLE) ? 7'h7F : snap_n[4 + 7*d_n +: 7];
      dp_n  = (state_n == S_IDLE) ? 1'b1 : snap_n[d_n];
      an_n  = (state_n == S_SHOW) ? ~(4'b0001 << d_n) : 4'hF;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         d           <= 2'd0;
         cnt         <= 16'd0;
         snap        <= '1;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         an          <= 4'hF;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         d           <= d_n;
         cnt         <= cnt_n;
         snap        <= snap_n;
         seg         <= seg_n;
         dp          <= dp_n;
         an          <= an_n;
         frame_start <= fs_n;
      end
   end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of scan order, blanking, frame coherence, enable drop and reset.
module tb_display_scan;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [27:0] seg_in = '1;
   logic [3:0]  dp_in = 4'hF;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;
   int          n_checks = 0;
   int          n_fail = 0;
   localparam logic [27:0] BASIC = {7'h4F, 7'h12, 7'h06, 7'h01};
   logic [6:0] digs [4] = '{7'h01, 7'h06, 7'h12, 7'h4F};
   logic [6:0] ndigs [4] = '{7'h00, 7'h06, 7'h12, 7'h7E};

   display_scan #(.DWELL(4), .BLANK(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // k counts negedges after the enabling edge; 2 blank + 4 show clocks per digit
   function automatic logic [3:0] exp_an(int k);
      return (k % 6 < 2) ? 4'hF : ~(4'b0001 << ((k / 6) % 4));
   endfunction

   task automatic start_scan(input logic [27:0] s, input logic [3:0] p);
      reset = 1'b1;
      enable = 1'b0;
      seg_in = s;
      dp_in = p;
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected f", an); end
      n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
      start_scan(BASIC, 4'h0);
      repeat (9) @(negedge clk);
      n_checks++; if (an !== 4'hD) begin n_fail++; $display("FAIL pre_reset_an: got %h expected d", an); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL async_an: got %h expected f", an); end
      n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL async_seg: got %h expected 7f", seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL async_dp: got %b expected 1", dp); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL async_fs: got %b expected 0", frame_start); end
      @(negedge clk);
      enable = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_dark: got an=%h seg=%h dp=%b expected f 7f 1", an, seg, dp);
         end
      end
   endtask

   task automatic test_basic_scan();
      start_scan(BASIC, 4'hF);
      for (int k = 0; k < 48; k++) begin
         n_checks++; if (an !== exp_an(k)) begin n_fail++; $display("FAIL scan_an k=%0d: got %h expected %h", k, an, exp_an(k)); end
         n_checks++; if (seg !== digs[(k / 6) % 4]) begin n_fail++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, digs[(k / 6) % 4]); end
         n_checks++; if (frame_start !== (k % 24 == 0)) begin n_fail++; $display("FAIL scan_fs k=%0d: got %b", k, frame_start); end
         @(negedge clk);
      end
   endtask

   task automatic test_coherence();
      logic [6:0] e;
      start_scan(BASIC, 4'hF);
      repeat (15) @(negedge clk);
      seg_in = {7'h7E, 7'h12, 7'h06, 7'h00};
      for (int k = 15; k < 48; k++) begin
         e = (k < 24) ? digs[(k / 6) % 4] : ndigs[(k / 6) % 4];
         n_checks++; if (seg !== e) begin n_fail++; $display("FAIL coherence_seg k=%0d: got %h expected %h", k, seg, e); end
         n_checks++; if (frame_start !== (k == 24)) begin n_fail++; $display("FAIL coherence_fs k=%0d: got %b", k, frame_start); end
         @(negedge clk);
      end
   endtask

   task automatic test_period();
      int last_fs = -1;
      int nfs = 0;
      int run = 0;
      int exp_run;
      logic [3:0] prev = 4'hF;
      start_scan(BASIC, 4'hF);
      for (int k = 0; k < 120; k++) begin
         n_checks++; if ($countones(~an) > 1) begin n_fail++; $display("FAIL onehot k=%0d: got an=%h expected at most one low", k, an); end
         if (frame_start) begin
            nfs++;
            if (last_fs >= 0) begin
               n_checks++; if (k - last_fs != 24) begin n_fail++; $display("FAIL fs_period: got %0d expected 24", k - last_fs); end
            end
            last_fs = k;
         end
         if (k > 0 && an !== prev) begin
            exp_run = (prev == 4'hF) ? 2 : 4;
            n_checks++; if (run != exp_run) begin n_fail++; $display("FAIL window k=%0d an=%h: got %0d expected %0d", k, prev, run, exp_run); end
            run = 1;
         end else run++;
         prev = an;
         @(negedge clk);
      end
      n_checks++; if (nfs != 5) begin n_fail++; $display("FAIL fs_count: got %0d expected 5", nfs); end
   endtask

   task automatic test_enable_drop();
      start_scan(BASIC, 4'hF);
      repeat (9) @(negedge clk);
      n_checks++; if (an !== 4'hD) begin n_fail++; $display("FAIL drop_pre_an: got %h expected d", an); end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL drop_dark %0d: got an=%h seg=%h dp=%b fs=%b expected f 7f 1 0", i, an, seg, dp, frame_start);
         end
      end
      enable = 1'b1;
      @(negedge clk);
      n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL restart_fs: got %b expected 1", frame_start); end
      n_checks++; if (an !== 4'hF || seg !== 7'h01) begin n_fail++; $display("FAIL restart_blank: got an=%h seg=%h expected f 01", an, seg); end
      @(negedge clk);
      n_checks++; if (frame_start !== 1'b0 || an !== 4'hF) begin n_fail++; $display("FAIL restart_blank2: got fs=%b an=%h expected 0 f", frame_start, an); end
      @(negedge clk);
      n_checks++; if (an !== 4'hE || seg !== 7'h01) begin n_fail++; $display("FAIL restart_d0: got an=%h seg=%h expected e 01", an, seg); end
   endtask

   task automatic test_dp();
      logic e;
      start_scan(BASIC, 4'b1010);
      for (int k = 0; k < 48; k++) begin
         if (exp_an(k) != 4'hF) begin
            e = ((k / 6) % 2) != 0;
            n_checks++; if (dp !== e) begin n_fail++; $display("FAIL dp k=%0d an=%h: got %b expected %b", k, an, dp, e); end
         end
         @(negedge clk);
      end
      enable = 1'b0;
      @(negedge clk);
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL dp_dark: got %b expected 1", dp); end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_coherence();
      test_period();
      test_enable_drop();
      test_dp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
